// File: rtl/display_pkg.sv
// Shared types and constants for the display sequencing controller.
// Code-timeout behaviour is selected with DISPLAY_CODE_TIMEOUT_EN.
package display_pkg;

  localparam int DP_W   = 3;
  localparam int CODE_W = 4;
  localparam int NUM_W  = 32;

  localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;
  localparam logic [CODE_W-1:0] CODE_OVF   = 4'hF;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_NUM,
    LOAD_CODE,
    HOLD,
    RESTORE
  } state_t;

  typedef struct packed {
    logic              mode;
    logic [DP_W-1:0]   dp;
    logic [CODE_W-1:0] codes;
    logic [NUM_W-1:0]  num;
  } disp_t;

endpackage

// File: rtl/hold_timer.sv
// Code hold timer: counts HOLD cycles, done on the last one.
// Only instantiated when DISPLAY_CODE_TIMEOUT_EN is defined.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/display_ctrl.sv
// Arbitrates number/code requests and sequences seven-segment display loads.
// DISPLAY_CODE_TIMEOUT_EN enables restoring the last number after a code.
module display_ctrl
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              num_req,
  input  logic [NUM_W-1:0]  num_data,
  input  logic [DP_W-1:0]   num_dp,
  output logic              num_ack,
  input  logic              code_req,
  input  logic [CODE_W-1:0] code_val,
  output logic              code_ack,
  output logic              disp_latch,
  output logic              disp_mode,
  output logic [DP_W-1:0]   disp_dp,
  output logic [CODE_W-1:0] disp_codes,
  output logic [NUM_W-1:0]  disp_num,
  output logic              busy
);

  state_t           state, state_n;
  disp_t            disp_q, disp_n;
  logic [NUM_W-1:0] last_num, last_num_n;
  logic [DP_W-1:0]  last_dp, last_dp_n;
  logic             sample;
  logic             restore;
  logic             done;

`ifdef DISPLAY_CODE_TIMEOUT_EN
  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state == LOAD_CODE),
    .enable(state == HOLD),
    .done  (done)
  );
`else
  logic unused_cfg;
  assign done       = 1'b0;
  assign unused_cfg = ^{last_num, last_dp,
                        HOLD_CYCLES[0], CNT_W[0]};
`endif

  // HOLD stays responsive to new requests, just like IDLE
  assign sample  = (state == IDLE) || (state == HOLD);
  assign restore = (state == HOLD) && done
                   && !code_req && !num_req;

  always_comb begin
    state_n    = state;
    disp_n     = disp_q;
    last_num_n = last_num;
    last_dp_n  = last_dp;
    unique case (1'b1)
      sample && code_req: begin
        disp_n.mode  = 1'b1;
        disp_n.codes = code_val;
        state_n      = LOAD_CODE;
      end
      sample && num_req && !code_req: begin
        disp_n.mode = 1'b0;
        disp_n.num  = num_data;
        disp_n.dp   = num_dp;
        last_num_n  = num_data;
        last_dp_n   = num_dp;
        state_n     = LOAD_NUM;
      end
      restore: begin
        disp_n.mode = 1'b0;
        disp_n.num  = last_num;
        disp_n.dp   = last_dp;
        state_n     = RESTORE;
      end
      (state == LOAD_NUM) || (state == RESTORE): begin
        state_n = IDLE;
      end
      state == LOAD_CODE: begin
`ifdef DISPLAY_CODE_TIMEOUT_EN
        state_n = HOLD;
`else
        state_n = IDLE;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      disp_q   <= '0;
      last_num <= '0;
      last_dp  <= '0;
    end else begin
      state    <= state_n;
      disp_q   <= disp_n;
      last_num <= last_num_n;
      last_dp  <= last_dp_n;
    end
  end

  assign num_ack    = (state == LOAD_NUM);
  assign code_ack   = (state == LOAD_CODE);
  assign disp_latch = (state == LOAD_NUM) || (state == LOAD_CODE)
                      || (state == RESTORE);
  assign busy       = (state != IDLE);
  assign disp_mode  = disp_q.mode;
  assign disp_dp    = disp_q.dp;
  assign disp_codes = disp_q.codes;
  assign disp_num   = disp_q.num;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed self-checking bench for display_ctrl (HOLD_CYCLES = 4).
// Follows DISPLAY_CODE_TIMEOUT_EN the same way the design does.
module tb_display_ctrl;

  logic        clock;
  logic        reset;
  logic        num_req;
  logic [31:0] num_data;
  logic [2:0]  num_dp;
  logic        num_ack;
  logic        code_req;
  logic [3:0]  code_val;
  logic        code_ack;
  logic        disp_latch;
  logic        disp_mode;
  logic [2:0]  disp_dp;
  logic [3:0]  disp_codes;
  logic [31:0] disp_num;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [43:0] obs;
  logic [43:0] e;

  display_ctrl #(.HOLD_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .num_req   (num_req),
    .num_data  (num_data),
    .num_dp    (num_dp),
    .num_ack   (num_ack),
    .code_req  (code_req),
    .code_val  (code_val),
    .code_ack  (code_ack),
    .disp_latch(disp_latch),
    .disp_mode (disp_mode),
    .disp_dp   (disp_dp),
    .disp_codes(disp_codes),
    .disp_num  (disp_num),
    .busy      (busy)
  );

  assign obs = {num_ack, code_ack, disp_latch, disp_mode, busy,
                disp_dp, disp_codes, disp_num};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [43:0] ev(
    input logic na, input logic ca, input logic lt,
    input logic md, input logic bz, input logic [2:0] dp,
    input logic [3:0] cd, input logic [31:0] nm);
    return {na, ca, lt, md, bz, dp, cd, nm};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; num_req = 1'b1; code_req = 1'b1;
    num_data = 32'd5; num_dp = 3'b101; code_val = 4'hE;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = '0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", obs, e);
      end
    end
    num_req = 1'b0; code_req = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_num;
    num_req = 1'b1; num_data = 32'd1234; num_dp = 3'b010;
    tick();
    e = ev(1, 0, 1, 0, 1, 3'b010, 4'h0, 32'd1234);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL num_load got=%h exp=%h", obs, e);
    end
    num_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = ev(0, 0, 0, 0, 0, 3'b010, 4'h0, 32'd1234);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL num_hold got=%h exp=%h", obs, e);
      end
    end
  endtask

  task automatic test_priority;
    logic hb;
`ifdef DISPLAY_CODE_TIMEOUT_EN
    hb = 1'b1;
`else
    hb = 1'b0;
`endif
    num_req = 1'b1; num_data = 32'd99; num_dp = 3'b001;
    code_req = 1'b1; code_val = 4'hE;
    tick();
    e = ev(0, 1, 1, 1, 1, 3'b010, 4'hE, 32'd1234);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL prio_code got=%h exp=%h", obs, e);
    end
    code_req = 1'b0;
    tick();
    e = ev(0, 0, 0, 1, hb, 3'b010, 4'hE, 32'd1234);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL prio_gap got=%h exp=%h", obs, e);
    end
    tick();
    e = ev(1, 0, 1, 0, 1, 3'b001, 4'hE, 32'd99);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL prio_num got=%h exp=%h", obs, e);
    end
    num_req = 1'b0;
    tick();
    e = ev(0, 0, 0, 0, 0, 3'b001, 4'hE, 32'd99);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL prio_idle got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_back_to_back;
    num_req = 1'b1; num_data = 32'd11; num_dp = 3'b111;
    tick();
    e = ev(1, 0, 1, 0, 1, 3'b111, 4'hE, 32'd11);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", obs, e);
    end
    num_data = 32'd22; num_dp = 3'b000;
    tick();
    e = ev(0, 0, 0, 0, 0, 3'b111, 4'hE, 32'd11);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL b2b_gap got=%h exp=%h", obs, e);
    end
    tick();
    e = ev(1, 0, 1, 0, 1, 3'b000, 4'hE, 32'd22);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", obs, e);
    end
    num_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    num_req = 1'b1; num_data = 32'd77; num_dp = 3'b000;
    tick();
    num_req = 1'b0;
    tick();
    code_req = 1'b1; code_val = 4'h3;
    tick();
    e = ev(0, 1, 1, 1, 1, 3'b000, 4'h3, 32'd77);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL to_load got=%h exp=%h", obs, e);
    end
    code_req = 1'b0;
`ifdef DISPLAY_CODE_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      e = ev(0, 0, 0, 1, 1, 3'b000, 4'h3, 32'd77);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL to_hold%0d got=%h exp=%h", i, obs, e);
      end
    end
    tick();
    e = ev(0, 0, 1, 0, 1, 3'b000, 4'h3, 32'd77);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL to_restore got=%h exp=%h", obs, e);
    end
    tick();
    e = ev(0, 0, 0, 0, 0, 3'b000, 4'h3, 32'd77);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL to_idle got=%h exp=%h", obs, e);
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      e = ev(0, 0, 0, 1, 0, 3'b000, 4'h3, 32'd77);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL code_stays%0d got=%h exp=%h", i, obs, e);
      end
    end
`endif
  endtask

`ifdef DISPLAY_CODE_TIMEOUT_EN
  task automatic test_restart;
    code_req = 1'b1; code_val = 4'h3;
    tick();
    code_req = 1'b0;
    tick();
    tick();
    code_req = 1'b1; code_val = 4'h5;
    tick();
    e = ev(0, 1, 1, 1, 1, 3'b000, 4'h5, 32'd77);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL rs_load got=%h exp=%h", obs, e);
    end
    code_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = ev(0, 0, 0, 1, 1, 3'b000, 4'h5, 32'd77);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rs_hold%0d got=%h exp=%h", i, obs, e);
      end
    end
    tick();
    e = ev(0, 0, 1, 0, 1, 3'b000, 4'h5, 32'd77);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL rs_restore got=%h exp=%h", obs, e);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    code_req = 1'b1; code_val = 4'h3;
    tick();
    code_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = '0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rst_mid%0d got=%h exp=%h", i, obs, e);
      end
      tick();
    end
`ifdef DISPLAY_CODE_TIMEOUT_EN
    code_req = 1'b1; code_val = 4'h9;
    tick();
    code_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tick();
    e = ev(0, 0, 1, 0, 1, 3'b000, 4'h9, 32'd0);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL restore_zero got=%h exp=%h", obs, e);
    end
    tick();
`endif
  endtask

  initial begin
    reset = 1'b0; num_req = 1'b0; code_req = 1'b0;
    num_data = '0; num_dp = '0; code_val = '0;
    test_reset();
    test_num();
    test_priority();
    test_back_to_back();
    test_timeout();
`ifdef DISPLAY_CODE_TIMEOUT_EN
    test_restart();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Sequencing controller in front of the calculator's seven-segment display datapath. Arbitrates between two requesters (arithmetic result path, status/code path), drives the display's latch/mode/dp/codes/num inputs with one-cycle latch pulses, and restores the last number after a status code has been shown for a fixed time. Sits between the calculator core and the display block.

## Interface

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles a code stays on screen before the last number is restored (1 s at 50 MHz); must be ≥ 1.
- CNT_W, default $clog2(HOLD_CYCLES+1): hold counter width.

Ports:
- clock  in  1  system clock; everything on rising edge
- reset  in  1  synchronous, active-low reset
- num_req  in  1  result path requests display of num_data/num_dp
- num_data  in  32  number to display
- num_dp  in  3  decimal point position (111 MSD … 000 LSD)
- num_ack  out  1  one-cycle pulse: number accepted
- code_req  in  1  code path requests display of code_val
- code_val  in  4  code to display
- code_ack  out  1  one-cycle pulse: code accepted
- disp_latch  out  1  one-cycle load strobe to display
- disp_mode  out  1  0 numbers, 1 codes
- disp_dp  out  3  dp to display
- disp_codes  out  4  code to display
- disp_num  out  32  number to display
- busy  out  1  high whenever state ≠ IDLE

## Operation

- States: IDLE, LOAD_NUM, LOAD_CODE, HOLD, RESTORE.
- IDLE: code_req=1 → capture code_val, go LOAD_CODE; else num_req=1 → capture num_data/num_dp into disp regs and last_num/last_dp, go LOAD_NUM; else stay.
- LOAD_NUM: disp_mode=0, disp_latch=1, num_ack=1 → IDLE.
- LOAD_CODE: disp_mode=1, disp_latch=1, code_ack=1 → HOLD (counter cleared).
- HOLD: counter increments each cycle. code_req=1 → capture new code, LOAD_CODE (timer restarts). Else num_req=1 → capture number, LOAD_NUM (hold aborted). Else counter == HOLD_CYCLES-1 → RESTORE.
- RESTORE: disp_num/disp_dp ← last_num/last_dp, disp_mode=0, disp_latch=1, no ack → IDLE.
- Priority: code over number whenever both requested in the same sampling cycle; losing request stays pending.
- disp_num, disp_dp, disp_codes, disp_mode are registered and hold their value between latch pulses; disp_codes unchanged by number loads and vice versa.
- Requester protocol: hold req and data stable until ack seen; drop req on the edge ending the ack cycle. Data is captured on the sampling edge only.

## Timing

- Reset (reset=0 on an edge): state IDLE, counter 0, all outputs 0, last_num 0, last_dp 000. Takes effect in the next cycle; in-flight request aborted and must be re-presented.
- Request sampled at edge N → ack, disp_latch and new disp_* valid together in cycle N+1.
- Back-to-back: next request sampled earliest at the edge ending the LOAD cycle+1 (IDLE cycle), i.e. one accept per 2 cycles.
- Code timeout: LOAD_CODE in cycle k → HOLD cycles k+1…k+HOLD_CYCLES → RESTORE latch in cycle k+HOLD_CYCLES+1.
- RESTORE with no prior number shows 0, dp 000.
- HOLD_CYCLES=1: exactly one HOLD cycle.

## Configuration

- DISPLAY_CODE_TIMEOUT_EN defined: behaviour as above.
- Not defined: HOLD, RESTORE and counter not built; LOAD_CODE → IDLE; code remains displayed until the next number is accepted. last_num registers still exist (no functional use), HOLD_CYCLES ignored.

## Structure

- Package display_pkg: state enum, DP_W=3, CODE_W=4, NUM_W=32, named code constants (CODE_ERR, CODE_OVF, CODE_BLANK).
- Sub-module hold_timer (clear, enable, done at HOLD_CYCLES-1), instantiated only under DISPLAY_CODE_TIMEOUT_EN.

## Test plan

- reset=0 two cycles with both reqs high → all outputs 0, no ack, busy 0.
- num_req, num_data=32'd1234, num_dp=3'b010 → next cycle num_ack=1, disp_latch=1, disp_mode=0, disp_num=1234, disp_dp=010; one-cycle pulses.
- num_req and code_req same edge, code_val=4'hE → code accepted first (disp_mode=1, disp_codes=E), number accepted in a later IDLE cycle.
- HOLD_CYCLES=4, number 77 shown, then code 4'h3 → latch at k, RESTORE latch at k+5 with disp_num=77, disp_mode=0.
- During HOLD, new code 4'h5 at hold cycle 2 → timer restarts; restore comes HOLD_CYCLES+1 after the second LOAD_CODE. Reset asserted mid-HOLD → IDLE, outputs 0, no restore pulse.
- Build without DISPLAY_CODE_TIMEOUT_EN → code stays displayed indefinitely; busy drops one cycle after LOAD_CODE.
